pkt_framing_guard: RTL and testbench

- Upstream stage placed directly in front of the packet sorter.
- Receives a raw Avalon-ST packet stream and repairs its framing: drops orphan beats, closes packets that are interrupted by a new sop, and truncates packets longer than MAX_PKT_LEN.
- Guarantees the sorter sees only well-formed packets of 1..MAX_PKT_LEN beats.
- Uses a one-beat hold register, so a beat's eop is decided before that beat is presented downstream.

---
 rtl/pkt_guard_pkg.sv | 23 ++
 rtl/sat_counter.sv | 19 +
 rtl/pkt_framing_guard.sv | 149 ++++++++++++++
 tb/tb_pkt_framing_guard.sv | 354 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pkt_guard_pkg.sv
// Shared types for the packet framing guard: FSM states, hold-register beat and len sizing.
package pkt_guard_pkg;

  localparam int unsigned BEAT_DWIDTH = 16;

  typedef enum logic [1:0] {
    IDLE_S = 2'd0,
    PKT_S  = 2'd1,
    DROP_S = 2'd2
  } state_t;

  typedef struct packed {
    logic [BEAT_DWIDTH-1:0] data;
    logic                   sop;
    logic                   eop;
  } beat_t;

  // Bits needed to count 0..max_len beats.
  function automatic int unsigned len_width(input int unsigned max_len);
    return $clog2(max_len + 1);
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Statistics counter that sticks at all-ones instead of wrapping.
module sat_counter #(
  parameter int unsigned CWIDTH = 16
) (
  input  logic              clk_i,
  input  logic              srst_i,
  input  logic              inc_i,
  output logic [CWIDTH-1:0] cnt_o
);

  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      cnt_o <= '0;
    end else if (inc_i && (cnt_o != '1)) begin
      cnt_o <= cnt_o + CWIDTH'(1);
    end
  end

endmodule

// File: rtl/pkt_framing_guard.sv
// Repairs Avalon-ST framing in front of the packet sorter: drops orphans, closes
// interrupted packets, truncates overlong ones. A one-beat hold register decides eop early.
module pkt_framing_guard
  import pkt_guard_pkg::*;
#(
  parameter int unsigned DWIDTH      = 16,
  parameter int unsigned MAX_PKT_LEN = 250,
  parameter int unsigned CWIDTH      = 16
) (
  input  logic              clk_i,
  input  logic              srst_i,
  input  logic [DWIDTH-1:0] snk_data_i,
  input  logic              snk_startofpacket_i,
  input  logic              snk_endofpacket_i,
  input  logic              snk_valid_i,
  output logic              snk_ready_o,
  output logic [DWIDTH-1:0] src_data_o,
  output logic              src_startofpacket_o,
  output logic              src_endofpacket_o,
  output logic              src_valid_o,
  input  logic              src_ready_i,
  output logic [CWIDTH-1:0] pkt_cnt_o,
  output logic [CWIDTH-1:0] trunc_cnt_o,
  output logic [CWIDTH-1:0] orphan_cnt_o,
  output logic [CWIDTH-1:0] broken_cnt_o
);

  localparam int unsigned        LWIDTH  = len_width(MAX_PKT_LEN);
  localparam logic [LWIDTH-1:0] LEN_MAX = LWIDTH'(MAX_PKT_LEN);
  localparam logic [LWIDTH-1:0] LEN_ONE = LWIDTH'(1);

  state_t            state_q, state_d;
  beat_t             h_q, h_d;
  logic              h_valid_q, h_valid_d;
  logic [LWIDTH-1:0] len_q, len_d;
  beat_t             in_beat;

  logic o_free;
  logic acc;
  logic xfer;
  logic xfer_eop;
  logic inc_pkt, inc_trunc, inc_orphan, inc_broken;

  assign o_free      = !src_valid_o || src_ready_i;
  assign snk_ready_o = o_free || !h_valid_q;
  assign acc         = snk_valid_i && snk_ready_o;
  assign in_beat     = {BEAT_DWIDTH'(snk_data_i), snk_startofpacket_i, snk_endofpacket_i};

  // Next-state, hold-register update and counter strobes.
  always_comb begin
    state_d    = state_q;
    h_d        = h_q;
    len_d      = len_q;
    xfer_eop   = h_q.eop;
    inc_trunc  = 1'b0;
    inc_orphan = 1'b0;
    inc_broken = 1'b0;

    // A held beat leaves once its eop is known: either flagged, or decided by the next beat.
    xfer      = h_valid_q && o_free && (h_q.eop || (acc && (state_q == PKT_S)));
    h_valid_d = h_valid_q && !xfer;

    unique case (state_q)
      IDLE_S, DROP_S: begin
        if (acc) begin
          if (snk_startofpacket_i) begin
            h_d       = in_beat;
            h_valid_d = 1'b1;
            len_d     = LEN_ONE;
            state_d   = snk_endofpacket_i ? IDLE_S : PKT_S;
          end else if (state_q == IDLE_S) begin
            inc_orphan = 1'b1;
          end else if (snk_endofpacket_i) begin
            state_d = IDLE_S;
          end
        end
      end

      PKT_S: begin
        if (acc) begin
          h_d       = in_beat;
          h_valid_d = 1'b1;
          if (snk_startofpacket_i) begin
            xfer_eop   = 1'b1;
            inc_broken = 1'b1;
            len_d      = LEN_ONE;
            state_d    = snk_endofpacket_i ? IDLE_S : PKT_S;
          end else begin
            len_d = len_q + LEN_ONE;
            if (snk_endofpacket_i) begin
              state_d = IDLE_S;
            end else if ((len_q + LEN_ONE) == LEN_MAX) begin
              h_d.eop   = 1'b1;
              inc_trunc = 1'b1;
              state_d   = DROP_S;
            end
          end
        end
      end

      default: state_d = IDLE_S;
    endcase

    inc_pkt = xfer && xfer_eop;
  end

  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      state_q             <= IDLE_S;
      h_q                 <= '0;
      h_valid_q           <= 1'b0;
      len_q               <= '0;
      src_valid_o         <= 1'b0;
      src_startofpacket_o <= 1'b0;
      src_endofpacket_o   <= 1'b0;
      src_data_o          <= '0;
    end else begin
      state_q   <= state_d;
      h_q       <= h_d;
      h_valid_q <= h_valid_d;
      len_q     <= len_d;
      if (xfer) begin
        src_valid_o         <= 1'b1;
        src_data_o          <= DWIDTH'(h_q.data);
        src_startofpacket_o <= h_q.sop;
        src_endofpacket_o   <= xfer_eop;
      end else if (src_ready_i) begin
        src_valid_o <= 1'b0;
      end
    end
  end

  sat_counter #(.CWIDTH(CWIDTH)) u_pkt_cnt (
    .clk_i (clk_i), .srst_i(srst_i), .inc_i(inc_pkt), .cnt_o(pkt_cnt_o)
  );

  sat_counter #(.CWIDTH(CWIDTH)) u_trunc_cnt (
    .clk_i (clk_i), .srst_i(srst_i), .inc_i(inc_trunc), .cnt_o(trunc_cnt_o)
  );

  sat_counter #(.CWIDTH(CWIDTH)) u_orphan_cnt (
    .clk_i (clk_i), .srst_i(srst_i), .inc_i(inc_orphan), .cnt_o(orphan_cnt_o)
  );

  sat_counter #(.CWIDTH(CWIDTH)) u_broken_cnt (
    .clk_i (clk_i), .srst_i(srst_i), .inc_i(inc_broken), .cnt_o(broken_cnt_o)
  );

endmodule

// File: tb/tb_pkt_framing_guard.sv
// Bench for pkt_framing_guard: cycle tables, directed corner sequences and a
// randomized run checked against a packet-level framing model.
module tb_pkt_framing_guard;

  localparam int unsigned DW   = 16;
  localparam int unsigned MAXL = 4;
  localparam int unsigned CW   = 8;

  logic          clk = 1'b0;
  logic          srst_i = 1'b1;
  logic [DW-1:0] snk_data_i = '0;
  logic          snk_startofpacket_i = 1'b0;
  logic          snk_endofpacket_i = 1'b0;
  logic          snk_valid_i = 1'b0;
  logic          snk_ready_o;
  logic [DW-1:0] src_data_o;
  logic          src_startofpacket_o;
  logic          src_endofpacket_o;
  logic          src_valid_o;
  logic          src_ready_i = 1'b1;
  logic [CW-1:0] pkt_cnt_o, trunc_cnt_o, orphan_cnt_o, broken_cnt_o;

  always #5 clk = ~clk;

  pkt_framing_guard #(.DWIDTH(DW), .MAX_PKT_LEN(MAXL), .CWIDTH(CW)) dut (
    .clk_i              (clk),
    .srst_i             (srst_i),
    .snk_data_i         (snk_data_i),
    .snk_startofpacket_i(snk_startofpacket_i),
    .snk_endofpacket_i  (snk_endofpacket_i),
    .snk_valid_i        (snk_valid_i),
    .snk_ready_o        (snk_ready_o),
    .src_data_o         (src_data_o),
    .src_startofpacket_o(src_startofpacket_o),
    .src_endofpacket_o  (src_endofpacket_o),
    .src_valid_o        (src_valid_o),
    .src_ready_i        (src_ready_i),
    .pkt_cnt_o          (pkt_cnt_o),
    .trunc_cnt_o        (trunc_cnt_o),
    .orphan_cnt_o       (orphan_cnt_o),
    .broken_cnt_o       (broken_cnt_o)
  );

  typedef struct packed {
    logic          sop;
    logic          eop;
    logic [DW-1:0] data;
  } tb_beat_t;

  typedef struct packed {
    logic          rst;
    logic          v, s, e;
    logic [DW-1:0] d;
    logic          ev, es, ee;
    logic [DW-1:0] ed;
    logic          er;
    logic          cchk;
    logic [CW-1:0] cp, co, cb, ct;
  } vec_t;

  tb_beat_t in_q[$];
  tb_beat_t out_q[$];
  tb_beat_t exp_q[$];
  vec_t     vecs[$];

  int   tests = 0;
  int   fails = 0;
  logic rnd_bp = 1'b0;
  logic stall_prev = 1'b0;
  logic [DW+1:0] snap = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_cnt(input string name, input int p, input int o, input int b, input int t);
    check(name, {pkt_cnt_o, orphan_cnt_o, broken_cnt_o, trunc_cnt_o},
          {CW'(p), CW'(o), CW'(b), CW'(t)});
  endtask

  // Handshake recorder plus output-stability check under backpressure.
  always @(negedge clk) begin
    if (!srst_i) begin
      if (snk_valid_i && snk_ready_o)
        in_q.push_back({snk_startofpacket_i, snk_endofpacket_i, snk_data_i});
      if (src_valid_o && src_ready_i)
        out_q.push_back({src_startofpacket_o, src_endofpacket_o, src_data_o});
      if (stall_prev)
        check("stall_stable", 32'({src_valid_o, src_startofpacket_o, src_endofpacket_o, src_data_o}),
              32'({1'b1, snap}));
    end
    stall_prev = src_valid_o && !src_ready_i && !srst_i;
    snap       = {src_startofpacket_o, src_endofpacket_o, src_data_o};
  end

  task automatic tick();
    @(posedge clk);
    #1;
    if (rnd_bp) src_ready_i = ($urandom_range(0, 3) != 0);
  endtask

  task automatic idle(input int n);
    snk_valid_i = 1'b0;
    repeat (n) tick();
  endtask

  task automatic do_reset();
    snk_valid_i = 1'b0;
    srst_i = 1'b1;
    tick();
    srst_i = 1'b0;
    in_q.delete();
    out_q.delete();
    exp_q.delete();
  endtask

  task automatic send(input logic [DW-1:0] d, input logic s, input logic e);
    logic ok;
    snk_valid_i = 1'b1;
    snk_data_i = d;
    snk_startofpacket_i = s;
    snk_endofpacket_i = e;
    for (int n = 0; n < 300; n++) begin
      @(negedge clk);
      ok = snk_ready_o;
      tick();
      if (ok) begin
        snk_valid_i = 1'b0;
        return;
      end
    end
    tests++;
    fails++;
    $display("FAIL send_timeout: beat %h never accepted", d);
    snk_valid_i = 1'b0;
  endtask

  task automatic expect_beat(input logic s, input logic e, input logic [DW-1:0] d);
    exp_q.push_back({s, e, d});
  endtask

  task automatic compare_q(input string name);
    check({name, "_len"}, 32'(out_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < out_q.size() && i < exp_q.size(); i++)
      check(name, 32'(out_q[i]), 32'(exp_q[i]));
  endtask

  function automatic int sat(input int x);
    return (x > 255) ? 255 : x;
  endfunction

  // Packet-level model: builds the repaired stream from every accepted input beat.
  task automatic model(output int np, output int no, output int nb, output int nt);
    tb_beat_t cur[$];
    bit inpkt, drop;
    inpkt = 0; drop = 0; np = 0; no = 0; nb = 0; nt = 0;
    exp_q.delete();
    foreach (in_q[i]) begin
      tb_beat_t b;
      b = in_q[i];
      if (b.sop) begin
        if (inpkt) begin
          cur[cur.size()-1].eop = 1'b1;
          foreach (cur[k]) exp_q.push_back(cur[k]);
          nb++; np++;
        end
        cur.delete();
        cur.push_back(b);
        inpkt = 1; drop = 0;
        if (b.eop) begin
          exp_q.push_back(b);
          np++; inpkt = 0;
        end
      end else if (inpkt) begin
        cur.push_back(b);
        if (b.eop || cur.size() == MAXL) begin
          if (!b.eop) begin
            cur[cur.size()-1].eop = 1'b1;
            nt++; drop = 1;
          end
          foreach (cur[k]) exp_q.push_back(cur[k]);
          np++; inpkt = 0;
        end
      end else if (drop) begin
        if (b.eop) drop = 0;
      end else begin
        no++;
      end
    end
    // The last beat of an unfinished packet is still waiting for its eop decision.
    if (inpkt)
      for (int k = 0; k < cur.size() - 1; k++) exp_q.push_back(cur[k]);
  endtask

  task automatic add(input logic rst, input logic v, input logic s, input logic e,
                     input logic [DW-1:0] d, input logic ev, input logic es,
                     input logic ee, input logic [DW-1:0] ed);
    vec_t r;
    r = '0;
    r.rst = rst; r.v = v; r.s = s; r.e = e; r.d = d;
    r.ev = ev; r.es = es; r.ee = ee; r.ed = ed; r.er = 1'b1;
    vecs.push_back(r);
  endtask

  task automatic add_cnt(input int p, input int o, input int b, input int t);
    int idx;
    idx = vecs.size() - 1;
    vecs[idx].cchk = 1'b1;
    vecs[idx].cp = CW'(p);
    vecs[idx].co = CW'(o);
    vecs[idx].cb = CW'(b);
    vecs[idx].ct = CW'(t);
  endtask

  initial begin
    int np, no, nb, nt;
    logic [19:0] act, exp;

    // Clean 3-beat packet
    add(1, 0, 0, 0, 16'h0000, 0, 0, 0, 16'h0000);
    add(0, 1, 1, 0, 16'h0005, 0, 0, 0, 16'h0000); add_cnt(0, 0, 0, 0);
    add(0, 1, 0, 0, 16'h0003, 0, 0, 0, 16'h0000);
    add(0, 1, 0, 1, 16'h0009, 1, 1, 0, 16'h0005);
    add(0, 0, 0, 0, 16'h0000, 1, 0, 0, 16'h0003);
    add(0, 0, 0, 0, 16'h0000, 1, 0, 1, 16'h0009);
    add(0, 0, 0, 0, 16'h0000, 0, 0, 0, 16'h0000); add_cnt(1, 0, 0, 0);
    // Two orphans then a single-beat packet
    add(1, 0, 0, 0, 16'h0000, 0, 0, 0, 16'h0000);
    add(0, 1, 0, 0, 16'h0011, 0, 0, 0, 16'h0000); add_cnt(0, 0, 0, 0);
    add(0, 1, 0, 0, 16'h0022, 0, 0, 0, 16'h0000);
    add(0, 1, 1, 1, 16'h00AA, 0, 0, 0, 16'h0000);
    add(0, 0, 0, 0, 16'h0000, 0, 0, 0, 16'h0000);
    add(0, 0, 0, 0, 16'h0000, 1, 1, 1, 16'h00AA);
    add(0, 0, 0, 0, 16'h0000, 0, 0, 0, 16'h0000); add_cnt(1, 2, 0, 0);
    // Packet interrupted by a new sop
    add(1, 0, 0, 0, 16'h0000, 0, 0, 0, 16'h0000);
    add(0, 1, 1, 0, 16'h0001, 0, 0, 0, 16'h0000);
    add(0, 1, 0, 0, 16'h0002, 0, 0, 0, 16'h0000);
    add(0, 1, 1, 0, 16'h0003, 1, 1, 0, 16'h0001);
    add(0, 1, 0, 1, 16'h0004, 1, 0, 1, 16'h0002);
    add(0, 0, 0, 0, 16'h0000, 1, 1, 0, 16'h0003);
    add(0, 0, 0, 0, 16'h0000, 1, 0, 1, 16'h0004);
    add(0, 0, 0, 0, 16'h0000, 0, 0, 0, 16'h0000); add_cnt(2, 0, 1, 0);

    @(posedge clk);
    #1;
    tick();
    srst_i = 1'b0;

    foreach (vecs[i]) begin
      if (vecs[i].rst) begin
        do_reset();
      end else begin
        snk_valid_i = vecs[i].v;
        snk_startofpacket_i = vecs[i].s;
        snk_endofpacket_i = vecs[i].e;
        snk_data_i = vecs[i].d;
        @(negedge clk);
        act = {src_valid_o, src_valid_o ? {src_startofpacket_o, src_endofpacket_o, src_data_o} : 18'h0,
               snk_ready_o};
        exp = {vecs[i].ev, vecs[i].ev ? {vecs[i].es, vecs[i].ee, vecs[i].ed} : 18'h0, vecs[i].er};
        check($sformatf("vec%0d", i), 32'(act), 32'(exp));
        if (vecs[i].cchk)
          check($sformatf("vec%0d_cnt", i), {pkt_cnt_o, orphan_cnt_o, broken_cnt_o, trunc_cnt_o},
                {vecs[i].cp, vecs[i].co, vecs[i].cb, vecs[i].ct});
        tick();
      end
    end
    snk_valid_i = 1'b0;

    // Truncation at MAX_PKT_LEN, then a short packet passes intact
    do_reset();
    for (int k = 1; k <= 7; k++) send(DW'(k), k == 1, k == 7);
    send(16'h0008, 1, 0);
    send(16'h0009, 0, 1);
    idle(5);
    expect_beat(1, 0, 16'h0001); expect_beat(0, 0, 16'h0002);
    expect_beat(0, 0, 16'h0003); expect_beat(0, 1, 16'h0004);
    expect_beat(1, 0, 16'h0008); expect_beat(0, 1, 16'h0009);
    compare_q("trunc_out");
    check_cnt("trunc_cnt", 2, 0, 0, 1);

    // Backpressure mid-packet
    do_reset();
    send(16'h0010, 1, 0);
    send(16'h0011, 0, 0);
    src_ready_i = 1'b0;
    snk_valid_i = 1'b1;
    snk_data_i = 16'h0012;
    snk_startofpacket_i = 1'b0;
    snk_endofpacket_i = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("bp_ready_low", 32'({snk_ready_o, src_valid_o, src_data_o}), 32'({1'b0, 1'b1, 16'h0010}));
      tick();
    end
    src_ready_i = 1'b1;
    send(16'h0012, 0, 0);
    send(16'h0013, 0, 1);
    idle(5);
    expect_beat(1, 0, 16'h0010); expect_beat(0, 0, 16'h0011);
    expect_beat(0, 0, 16'h0012); expect_beat(0, 1, 16'h0013);
    compare_q("bp_out");
    check_cnt("bp_cnt", 1, 0, 0, 0);

    // Reset in the middle of a packet
    do_reset();
    send(16'h0021, 1, 0);
    send(16'h0022, 0, 0);
    src_ready_i = 1'b0;
    srst_i = 1'b1;
    tick();
    srst_i = 1'b0;
    src_ready_i = 1'b1;
    @(negedge clk);
    check("rst_mid_valid", 32'({src_valid_o, snk_ready_o}), 32'({1'b0, 1'b1}));
    check_cnt("rst_mid_cnt0", 0, 0, 0, 0);
    tick();
    send(16'h0023, 0, 0);
    send(16'h0024, 0, 0);
    send(16'h0025, 0, 1);
    idle(4);
    compare_q("rst_mid_out");
    check_cnt("rst_mid_cnt", 0, 3, 0, 0);

    // Counter saturation
    do_reset();
    for (int k = 0; k < 260; k++) send(DW'(k), 0, 0);
    idle(2);
    check_cnt("sat_cnt", 0, 255, 0, 0);

    // Randomized traffic with random backpressure
    do_reset();
    rnd_bp = 1'b1;
    for (int k = 0; k < 700; k++) begin
      if ($urandom_range(0, 4) == 0) idle(1);
      else send(DW'($urandom), $urandom_range(0, 2) == 0, $urandom_range(0, 2) == 0);
    end
    rnd_bp = 1'b0;
    src_ready_i = 1'b1;
    idle(8);
    model(np, no, nb, nt);
    compare_q("rand_out");
    check_cnt("rand_cnt", sat(np), sat(no), sat(nb), sat(nt));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
